// File: rtl/vend_pkg.sv
// Shared types and price helpers for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    CHANGE = 2'd2
  } vend_state_e;

  localparam int MAX_ITEMS  = 16;
  localparam int MAX_VAL_W  = 32;
  localparam int MAX_LIST_W = MAX_ITEMS * MAX_VAL_W;

  localparam logic [4*10-1:0] DEF_PRICE_LIST = {10'd30, 10'd20, 10'd10, 10'd5};

  // list is the packed price vector zero-extended to MAX_LIST_W; result is masked to val_w bits
  function automatic logic [MAX_VAL_W-1:0] price_of(input logic [MAX_LIST_W-1:0] list,
                                                    input int val_w, input int idx);
    return MAX_VAL_W'(list >> (idx * val_w)) & ~({MAX_VAL_W{1'b1}} << val_w);
  endfunction

endpackage

// File: rtl/vend_price_cmp.sv
// Affordability vector: bit i set when credit covers the price of item i.
module vend_price_cmp
  import vend_pkg::*;
#(
  parameter int                         N_ITEMS    = 4,
  parameter int                         VAL_W      = 10,
  parameter logic [N_ITEMS*VAL_W-1:0]   PRICE_LIST = DEF_PRICE_LIST
) (
  input  logic [VAL_W-1:0]   credit,
  output logic [N_ITEMS-1:0] afford
);

  localparam logic [MAX_LIST_W-1:0] LIST_EXT = MAX_LIST_W'(PRICE_LIST);

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_cmp
    localparam logic [MAX_VAL_W-1:0] P = price_of(LIST_EXT, VAL_W, i);
    assign afford[i] = credit >= P[VAL_W-1:0];
  end

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-item vending session controller: coin accumulation, vend, change, cancel and timeout.
// All outputs registered; an input sampled at one edge shows at the outputs after that edge.
module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int                       N_ITEMS     = 4,
  parameter int                       VAL_W       = 10,
  parameter logic [N_ITEMS*VAL_W-1:0] PRICE_LIST  = DEF_PRICE_LIST,
  parameter int                       TIMEOUT_CYC = 1000,
  parameter int                       IDX_W       = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [VAL_W-1:0]   coin_amt,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic               cancel,
  input  logic               get_ind,
  output logic               op_start,
  output logic [VAL_W-1:0]   credit,
  output logic [N_ITEMS-1:0] item_light,
  output logic               light,
  output logic               hold_ind,
  output logic               not_enough,
  output logic               coin_reject,
  output logic               vend_valid,
  output logic [IDX_W-1:0]   vend_idx,
  output logic               change_valid,
  output logic [VAL_W-1:0]   change_amt
);

  localparam int                    TMR_W     = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam int                    N_SLOTS   = 1 << IDX_W;
  localparam logic [IDX_W:0]        N_ITEMS_W = (IDX_W + 1)'(N_ITEMS);
  localparam logic [MAX_LIST_W-1:0] LIST_EXT  = MAX_LIST_W'(PRICE_LIST);

  // Padded to a power of two so any sel_idx indexes a defined entry.
  logic [VAL_W-1:0] price_tbl [N_SLOTS];
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_tbl
    if (i < N_ITEMS) begin : g_item
      localparam logic [MAX_VAL_W-1:0] P = price_of(LIST_EXT, VAL_W, i);
      assign price_tbl[i] = P[VAL_W-1:0];
    end else begin : g_pad
      assign price_tbl[i] = '0;
    end
  end

  vend_state_e        state_q, state_d;
  logic [VAL_W-1:0]   credit_q, credit_d;
  logic               hold_q, hold_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               op_start_q, op_start_d;
  logic [N_ITEMS-1:0] item_light_q, item_light_d;
  logic               light_q, light_d;
  logic               not_enough_q, not_enough_d;
  logic               coin_reject_q, coin_reject_d;
  logic               vend_valid_q, vend_valid_d;
  logic [IDX_W-1:0]   vend_idx_q, vend_idx_d;
  logic               change_valid_q, change_valid_d;
  logic [VAL_W-1:0]   change_amt_q, change_amt_d;

  logic [VAL_W:0]   coin_sum;
  logic             coin_fits, sel_req, sel_ok, idle_cyc, timeout, leave, in_credit;
  logic [VAL_W-1:0] sel_price;

  // Selection affordability uses the pre-coin credit.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_amt};
  assign coin_fits = ~coin_sum[VAL_W];
  assign sel_price = price_tbl[sel_idx];
  assign sel_req   = sel_valid & ~cancel & ({1'b0, sel_idx} < N_ITEMS_W);
  assign sel_ok    = sel_price <= credit_q;
  assign idle_cyc  = ~coin_valid & ~sel_valid;
  assign timeout   = idle_cyc & (tmr_q == TMR_LAST);
  assign leave     = cancel | (get_ind & hold_q) | timeout;
  assign in_credit = state_q == CREDIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      hold_q         <= 1'b0;
      tmr_q          <= '0;
      op_start_q     <= 1'b0;
      item_light_q   <= '0;
      light_q        <= 1'b0;
      not_enough_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_valid_q   <= 1'b0;
      vend_idx_q     <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      hold_q         <= hold_d;
      tmr_q          <= tmr_d;
      op_start_q     <= op_start_d;
      item_light_q   <= item_light_d;
      light_q        <= light_d;
      not_enough_q   <= not_enough_d;
      coin_reject_q  <= coin_reject_d;
      vend_valid_q   <= vend_valid_d;
      vend_idx_q     <= vend_idx_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    hold_d   = hold_q;
    tmr_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (coin_valid) begin
          state_d  = CREDIT;
          credit_d = coin_amt;
        end
      end
      CREDIT: begin
        if (coin_valid && coin_fits) credit_d = coin_sum[VAL_W-1:0];
        if (sel_req && sel_ok) begin
          credit_d = credit_d - sel_price;
          hold_d   = 1'b1;
        end
        tmr_d = idle_cyc ? tmr_q + TMR_W'(1) : '0;
        if (leave) state_d = CHANGE;
      end
      CHANGE: begin
        state_d  = IDLE;
        credit_d = '0;
        hold_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
        hold_d   = 1'b0;
      end
    endcase
  end

  vend_price_cmp #(
    .N_ITEMS    (N_ITEMS),
    .VAL_W      (VAL_W),
    .PRICE_LIST (PRICE_LIST)
  ) u_price_cmp (
    .credit (credit_d),
    .afford (item_light_d)
  );

  always_comb begin
    op_start_d     = state_d != IDLE;
    light_d        = |item_light_d;
    not_enough_d   = in_credit & sel_req & ~sel_ok;
    coin_reject_d  = in_credit & coin_valid & ~coin_fits;
    vend_valid_d   = in_credit & sel_req & sel_ok;
    vend_idx_d     = vend_valid_d ? sel_idx : '0;
    change_valid_d = state_d == CHANGE;
    change_amt_d   = change_valid_d ? credit_d : '0;
  end

  assign op_start     = op_start_q;
  assign credit       = credit_q;
  assign item_light   = item_light_q;
  assign light        = light_q;
  assign hold_ind     = hold_q;
  assign not_enough   = not_enough_q;
  assign coin_reject  = coin_reject_q;
  assign vend_valid   = vend_valid_q;
  assign vend_idx     = vend_idx_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;

endmodule

// File: doc/vend_fsm_multi.md
Name: vend_fsm_multi

Overview:
Parametrised successor to the single-product vending controller. Handles N_ITEMS products with per-item prices and per-cycle coin increments, so the credit total is no longer driven externally. Supports multiple purchases per session, explicit change output, cancel-refund and an inactivity timeout. Sits between the coin/keypad front-end and the dispenser/display drivers.

Parameters:
N_ITEMS, 4, number of products; range 2..16.
VAL_W, 10, width of all money values, in half-yuan units.
PRICE_LIST, {10'd30,10'd20,10'd10,10'd5}, packed N_ITEMS*VAL_W vector; item i occupies bits [i*VAL_W +: VAL_W].
TIMEOUT_CYC, 1000, idle cycles in CREDIT before an automatic refund.
IDX_W, $clog2(N_ITEMS), width of the item index (derived).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
coin_valid  in  1  one-cycle strobe: coin inserted
coin_amt  in  VAL_W  coin value, sampled with coin_valid
sel_valid  in  1  one-cycle strobe: purchase request
sel_idx  in  IDX_W  requested item
cancel  in  1  abort session, refund credit
get_ind  in  1  customer took goods; ends session
op_start  out  1  session active (state != IDLE)
credit  out  VAL_W  current credit
item_light  out  N_ITEMS  bit i = credit >= price[i]
light  out  1  OR of item_light
hold_ind  out  1  at least one item vended this session
not_enough  out  1  one-cycle pulse: selection refused for lack of credit
coin_reject  out  1  one-cycle pulse: coin would overflow credit
vend_valid  out  1  one-cycle pulse: dispense item
vend_idx  out  IDX_W  item being dispensed, valid with vend_valid
change_valid  out  1  one-cycle pulse: pay out change
change_amt  out  VAL_W  change value, valid with change_valid

Behaviour:
- Reset: state IDLE; every output 0, including credit, item_light and hold_ind. Reset mid-session discards credit; no change_valid is issued.
- All outputs are registered. An input sampled at edge t is reflected at t+1. item_light and light are computed from the next credit value, so they update in the same cycle as credit.
- States: IDLE, CREDIT, CHANGE.
- IDLE: an accepted coin moves to CREDIT. sel_valid, get_ind and cancel are ignored.
- CREDIT, coins: if credit + coin_amt > 2^VAL_W-1, pulse coin_reject and leave credit unchanged. Otherwise add the coin.
- CREDIT, selections:
  - sel_idx >= N_ITEMS: ignore silently.
  - price <= credit: credit -= price; pulse vend_valid with vend_idx; set hold_ind.
  - Otherwise: pulse not_enough; credit unchanged.
- Same-cycle coin and selection: compare the price against the pre-coin credit. New credit = credit + coin - (price if vended).
- CREDIT to CHANGE on cancel, on get_ind when hold_ind = 1, or on timeout. get_ind when hold_ind = 0 is ignored.
- Precedence: cancel beats sel_valid in the same cycle, so no vend occurs. A coin in the same cycle as cancel is still added, then refunded.
- Timeout: counter clears on any coin_valid or sel_valid. Reaching TIMEOUT_CYC-1 while in CREDIT causes the transition to CHANGE.
- CHANGE, one cycle: change_valid = 1, change_amt = credit (0 is legal). At the next edge: credit, hold_ind and item_light clear; state returns to IDLE. Inputs in CHANGE are ignored.
- Width rule: subtraction never underflows because it is guarded by the compare. The adder is VAL_W+1 bits wide for the overflow check.

Decomposition:
- Package vend_pkg holds:
  - the state typedef (IDLE=2'd0, CREDIT=2'd1, CHANGE=2'd2);
  - a default price-list constant;
  - a price-extraction function price_of(list, idx).
- One sub-module: vend_price_cmp. It takes the price list and a credit value and produces the N_ITEMS affordability vector; it is reused for item_light.

Test Plan:
- Coins 2, 2, 2, then 20, each a one-cycle strobe -> credit reads 2, 4, 6, 26 one cycle after each strobe; item_light = 4'b0111; op_start = 1 from the first coin.
- At credit 26, select idx 1 (price 10) then idx 0 (price 5) -> vend_valid pulses with idx 1 and idx 0; credit 16 then 11; hold_ind = 1. Then get_ind -> change_valid with change_amt = 11; IDLE one cycle later.
- At credit 6, select idx 2 (price 20) -> not_enough pulse; credit stays 6; no vend_valid. Then cancel -> change_amt = 6; hold_ind stays 0.
- Same cycle: credit 6, coin 4 and sel idx 1 -> not_enough (pre-coin compare); credit becomes 10.
- Credit 1020, coin 10 -> coin_reject; credit stays 1020. Coin 2 with cancel in the same cycle -> change_amt = 1022.
- Credit 20, wait TIMEOUT_CYC cycles with no strobes -> change_valid with change_amt = 20. Separately, assert reset at credit 20 -> all outputs 0 next cycle, no change_valid.
